// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer behind the UART receiver FSM. Each completed
//   frame (one-cycle wr_valid strobe) is stored together with its frame-error
//   flag in a circular FIFO. The core drains it through rd_en and gets a
//   registered result one cycle later, marked by a one-cycle rd_valid pulse.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_data/wr_ferr     : byte and frame-error flag from the receiver
//   wr_valid            : one-cycle strobe qualifying wr_data/wr_ferr
//   rd_en               : read request from the core
//   rd_data/rd_ferr     : registered read result (held between reads)
//   rd_valid            : one-cycle pulse, rd_data/rd_ferr just updated
//   empty/full/count    : fill level, all decoded from the registered count
//   overrun             : sticky, a write was dropped because of a full FIFO
//   clr_overrun         : one-cycle clear of overrun (a same-cycle drop wins)
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ferr,
  input  logic                  wr_valid,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ferr,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic                  ferr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  rd_acc, wr_acc, drop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);

  // A read in the same cycle frees a slot, so a full FIFO still takes the
  // write. An empty FIFO never forwards the incoming byte (no bypass).
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_valid && (!full || rd_acc);
  assign drop   = wr_valid && full && !rd_acc;

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= '{ferr: wr_ferr, data: wr_data};
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port; data holds its last value when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_ferr  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr].data;
        rd_ferr <= mem[rd_ptr].ferr;
      end
    end
  end

  // Sticky overrun; a drop in the same cycle as the clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n)           overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the driver keeps a reference FIFO and
// pushes each expected read result into a queue; a negedge monitor pops and
// compares whenever rd_valid is seen, and checks the status outputs.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ferr = 1'b0;
  logic       wr_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_ferr;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_ferr(wr_ferr),
    .wr_valid(wr_valid), .rd_en(rd_en), .rd_data(rd_data), .rd_ferr(rd_ferr),
    .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  logic [8:0] mq[$];   // reference contents {ferr,data}
  logic [8:0] sb[$];   // expected read results, oldest first
  logic [8:0] exp_last = '0;
  bit         exp_rv = 1'b0;
  bit         m_ovr = 1'b0;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the reference model across the edge.
  task automatic step(input bit rst, input bit wv, input logic [7:0] wd,
                      input bit wf, input bit re, input bit clr);
    bit racc, mfull;
    logic [8:0] e;
    rst_n = !rst; wr_valid = wv; wr_data = wd; wr_ferr = wf;
    rd_en = re; clr_overrun = clr;
    @(posedge clk);
    if (rst) begin
      mq.delete(); sb.delete();
      m_ovr = 1'b0; exp_rv = 1'b0; exp_last = '0;
    end else begin
      mfull = (mq.size() == 16);
      racc  = re && (mq.size() > 0);
      exp_rv = racc;
      if (racc) begin
        e = mq.pop_front();
        sb.push_back(e);
        exp_last = e;
      end
      if (wv && (!mfull || racc)) mq.push_back({wf, wd});
      if (wv && mfull && !racc) m_ovr = 1'b1;
      else if (clr)             m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_en) begin
      chk("rd_valid", rd_valid, exp_rv);
      if (rd_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got 0x%0h with nothing expected", rd_data);
        end else begin
          e = sb.pop_front();
          chk("rd_data", rd_data, e[7:0]);
          chk("rd_ferr", rd_ferr, e[8]);
        end
      end
      chk("rd_data_hold", {rd_ferr, rd_data}, exp_last);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 16);
      chk("overrun", overrun, m_ovr);
    end
  end

  initial begin
    // reset, idle, reads on empty FIFO
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    chk_en = 1'b1;
    idle(2);
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    idle(1);

    // two bytes, second with frame error
    step(0, 1, 8'h30, 0, 0, 0);
    step(0, 1, 8'h31, 1, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    idle(2);

    // fill, drop 0xAA, drain, clear overrun
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0, 0);
    step(0, 1, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1, 0);
    idle(1);
    step(0, 0, 8'h00, 0, 0, 1);
    idle(1);

    // full FIFO with simultaneous write and read
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h40 + i), i[0], 0, 0);
    step(0, 1, 8'h55, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1, 0);
    idle(1);

    // wrap-around: alternating write/read, pointers cross 15 -> 0
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 8'(8'h80 + i), i[1], 0, 0);
      step(0, 0, 8'h00, 0, 1, 0);
    end
    // write and read together on an empty FIFO (read rejected), then mid-level
    step(0, 1, 8'hC0, 0, 1, 0);
    step(0, 1, 8'hC1, 1, 1, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    idle(1);

    // reset with 5 entries and a read in flight
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hD0 + i), 0, 0, 0);
    step(1, 0, 8'h00, 0, 1, 0);
    idle(1);
    step(0, 0, 8'h00, 0, 1, 0);
    idle(1);

    // drop coincident with clr_overrun: set wins
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'hE0 + i), 0, 0, 0);
    step(0, 1, 8'hEE, 0, 0, 1);
    idle(1);
    step(0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1, 0);
    idle(2);

    chk_en = 1'b0;
    chk("pending_reads", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
